// File: rtl/uart_tx.sv
// 8-bit-style UART transmitter clocked by a 16x baud tick; LSB first, idle high.
// Define UART_TX_PARITY_EN to insert a parity bit (sense from PARITY_ODD) before the stop bit.
module uart_tx #(
   parameter int DBIT       = 8,
   parameter int SB_TICK    = 16,
   parameter int PARITY_ODD = 0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            s_tick,
   input  logic            tx_start,
   input  logic [DBIT-1:0] tx_dato_in,
   output logic            tx_done,
   output logic            tx_busy,
   output logic            tx
);

   localparam int BW = (DBIT > 1) ? $clog2(DBIT) : 1;
   // Counter widens only when the stop bit needs more than 16 ticks.
   localparam int TW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   function automatic logic parity_f(input logic [DBIT-1:0] d);
      return (^d) ^ (PARITY_ODD != 0);
   endfunction
`else
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd4
   } state_t;
`endif

   if ((PARITY_ODD != 0) && (PARITY_ODD != 1)) begin : g_bad_parity_odd
      $error("uart_tx: PARITY_ODD must be 0 or 1");
   end

   state_t            state_q, state_d;
   logic [TW-1:0]     tick_q, tick_d;
   logic [BW-1:0]     bit_q, bit_d;
   logic [DBIT-1:0]   shift_q, shift_d;
   logic              par_q, par_d;
   logic              armed_q, armed_d;
   logic              tx_q, tx_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;

   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      armed_d = armed_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (tx_start && armed_q) begin
               shift_d = tx_dato_in;
`ifdef UART_TX_PARITY_EN
               par_d   = parity_f(tx_dato_in);
`else
               par_d   = 1'b0;
`endif
               armed_d = 1'b0;
               tick_d  = '0;
               state_d = START;
            end else if (!tx_start) begin
               armed_d = 1'b1;
            end else begin
               armed_d = armed_q;
            end
         end
         START: begin
            if (s_tick) begin
               if (tick_q == TW'(15)) begin
                  tick_d  = '0;
                  bit_d   = '0;
                  state_d = DATA;
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end else begin
               tick_d = tick_q;
            end
         end
         DATA: begin
            if (s_tick) begin
               if (tick_q == TW'(15)) begin
                  shift_d = shift_q >> 1;
                  tick_d  = '0;
                  bit_d   = bit_q + BW'(1);
                  if (bit_q == BW'(DBIT - 1)) begin
`ifdef UART_TX_PARITY_EN
                     state_d = PARITY;
`else
                     state_d = STOP;
`endif
                  end else begin
                     state_d = DATA;
                  end
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end else begin
               tick_d = tick_q;
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (s_tick) begin
               if (tick_q == TW'(15)) begin
                  tick_d  = '0;
                  state_d = STOP;
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end else begin
               tick_d = tick_q;
            end
         end
`endif
         STOP: begin
            if (s_tick) begin
               if (tick_q == TW'(SB_TICK - 1)) begin
                  tick_d  = '0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end else begin
               tick_d = tick_q;
            end
         end
         default: begin
            state_d = IDLE;
            tick_d  = '0;
         end
      endcase

      // Outputs are registered, so they are decoded from the next state.
      case (state_d)
         IDLE:    tx_d = 1'b1;
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  tx_d = par_d;
`endif
         STOP:    tx_d = 1'b1;
         default: tx_d = 1'b1;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         armed_q <= 1'b1;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         armed_q <= armed_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign tx      = tx_q;
   assign tx_done = done_q;
   assign tx_busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame contents, tick-accurate length, re-arm and reset-abort.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int NBITS       = 1 + 8 + PAR + 1;
   localparam int FRAME_TICKS = NBITS * 16;

   logic       clk = 1'b0;
   logic       reset;
   logic       s_tick;
   logic       tx_start;
   logic [7:0] tx_dato_in;
   logic       tx_done;
   logic       tx_busy;
   logic       tx;

   int n_checks = 0;
   int n_fail   = 0;

   uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY_ODD(0)) dut (
      .clk        (clk),
      .reset      (reset),
      .s_tick     (s_tick),
      .tx_start   (tx_start),
      .tx_dato_in (tx_dato_in),
      .tx_done    (tx_done),
      .tx_busy    (tx_busy),
      .tx         (tx)
   );

   always #5 clk = ~clk;

   // Baud tick: one clk-wide pulse every 4 clocks.
   initial begin
      s_tick = 1'b0;
      forever begin
         repeat (3) @(posedge clk);
         #1 s_tick = 1'b1;
         @(posedge clk);
         #1 s_tick = 1'b0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_tick(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         if (s_tick === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      #1;
   endtask

   // Wait for the start bit, sample every bit at mid-bit and time tx_done in ticks.
   task automatic run_frame(input string tag, input logic [7:0] exp, input bit poke, input bit drop);
      int          lat;
      int          done_t;
      bit          ok;
      logic [15:0] got_bits;
      logic [15:0] exp_bits;
      lat      = 0;
      done_t   = 0;
      got_bits = 16'h0000;
      exp_bits = 16'h0000;
      while (tx !== 1'b0 && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check_eq({tag, "_accept_lat"}, lat, 1);
      if (poke) tx_dato_in = 8'hFF;
      for (int t = 1; t <= FRAME_TICKS + 16; t++) begin
         wait_tick(ok);
         if (!ok) begin
            check_eq({tag, "_tick_timeout"}, 0, 1);
            break;
         end
         if ((t % 16) == 8 && (t / 16) < NBITS) got_bits[t/16] = tx;
         if (tx_done === 1'b1) begin
            done_t = t;
            break;
         end
      end
      exp_bits[0]   = 1'b0;
      exp_bits[8:1] = exp;
      if (PAR == 1) exp_bits[9] = ^exp;
      exp_bits[NBITS-1] = 1'b1;
      check_eq({tag, "_len_ticks"}, done_t, FRAME_TICKS);
      check_eq({tag, "_bits"}, got_bits, exp_bits);
      check_eq({tag, "_busy_at_done"}, tx_busy, 0);
      if (drop) tx_start = 1'b0;
      @(posedge clk);
      #1;
      check_eq({tag, "_done_pulse"}, tx_done, 0);
   endtask

   initial begin
      int  busy_seen;
      int  lat;
      bit  ok;
      reset      = 1'b1;
      tx_start   = 1'b0;
      tx_dato_in = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_tx", tx, 1);
      check_eq("rst_done", tx_done, 0);
      check_eq("rst_busy", tx_busy, 0);
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Frame A: 'p', data changed to FF during START, tx_start held past tx_done.
      tx_start   = 1'b1;
      tx_dato_in = 8'h70;
      run_frame("frame_p", 8'h70, 1'b1, 1'b0);
      tx_start = 1'b0;
      busy_seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (tx_busy === 1'b1 || tx !== 1'b1) busy_seen++;
      end
      check_eq("single_frame", busy_seen, 0);

      // Frame B: '0', tx_start dropped exactly at tx_done.
      tx_start   = 1'b1;
      tx_dato_in = 8'h30;
      run_frame("frame_0", 8'h30, 1'b0, 1'b1);

      // Frame C starts at the earliest cycle after tx_done.
      tx_start   = 1'b1;
      tx_dato_in = 8'h70;
      run_frame("frame_early", 8'h70, 1'b0, 1'b0);

      // Abort a frame in the middle of data bit 3.
      tx_start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      tx_start = 1'b1;
      lat = 0;
      while (tx !== 1'b0 && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check_eq("abort_accept_lat", lat, 1);
      for (int t = 0; t < 72; t++) wait_tick(ok);
      check_eq("abort_mid_bit3", tx, 0);
      check_eq("abort_busy_before", tx_busy, 1);
      reset      = 1'b1;
      tx_dato_in = 8'h30;
      @(posedge clk);
      #1;
      check_eq("abort_tx", tx, 1);
      check_eq("abort_busy", tx_busy, 0);
      check_eq("abort_done", tx_done, 0);
      repeat (2) @(posedge clk);
      #1;
      check_eq("abort_done_hold", tx_done, 0);
      reset = 1'b0;
      run_frame("frame_after_rst", 8'h30, 1'b0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
